// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, sequencer states and op-class helpers.
// Used by seq_alu and seq_alu_muldiv_core.
package alu_pkg;

    // The base RV32I encodings 0-9 are unchanged from the combinational ALU.
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLTU   = 5'd5,
        OP_SLT    = 5'd6,
        OP_SLL    = 5'd7,
        OP_SRL    = 5'd8,
        OP_SRA    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } ALU_Ops;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } seq_alu_state_t;

    function automatic logic is_base(input logic [4:0] op);
        return op <= OP_SRA;
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_mul(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_MULHU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv_core.sv
// Iterative multiply/divide engine: unsigned shift-add multiply and restoring divide on
// operand magnitudes, one step per cycle, with the sign fix-up applied to the final value.
module seq_alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [4:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W = DATA_WIDTH;

    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0]       acc;
    logic [W-1:0]         opnd;
    logic [4:0]           op_q;
    logic                 neg_main;
    logic                 neg_rem;

    logic                 a_signed;
    logic                 b_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [W-1:0]         mag_a;
    logic [W-1:0]         mag_b;
    logic [W:0]           mul_sum;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;
    logic [2*W-1:0]       prod;

    always_comb begin
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg    = a_signed && a_i[W-1];
        b_neg    = b_signed && b_i[W-1];
        mag_a    = a_neg ? (~a_i + 1'b1) : a_i;
        mag_b    = b_neg ? (~b_i + 1'b1) : b_i;
    end

    // acc holds {partial product} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (start_i) begin
            cnt      <= CNT_WIDTH'(W);
            op_q     <= op_i;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            if (is_mul(op_i)) begin
                acc  <= {{W{1'b0}}, mag_b};
                opnd <= mag_a;
            end else begin
                acc  <= {{W{1'b0}}, mag_a};
                opnd <= mag_b;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (is_mul(op_q)) begin
                acc <= {mul_sum, acc[W-1:1]};
            end else if (!div_diff[W]) begin
                acc <= {div_diff[W-1:0], acc[W-2:0], 1'b1};
            end else begin
                acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
            end
        end
    end

    assign done_o = (cnt == CNT_WIDTH'(1));

    always_comb begin
        prod     = neg_main ? (~acc + 1'b1) : acc;
        result_o = '0;
        case (op_q)
            OP_MUL:                       result_o = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod[2*W-1:W];
            OP_DIV, OP_DIVU:              result_o = neg_main ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
            OP_REM, OP_REMU:              result_o = neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
            default:                      result_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multicycle RV32I/M ALU: base ops complete in one registered cycle, M ops use an iterative core.
// Build option SEQ_ALU_MULDIV_EN: when undefined, all M ops are reported as illegal.
module seq_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    input  logic [4:0]            func_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] y_o,
    output logic                  illegal_o
);
    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);

    generate
        if (DATA_WIDTH < 8 || (DATA_WIDTH % 2) != 0 || CNT_WIDTH < SHW + 1) begin : g_param_check
            $error("seq_alu: unsupported DATA_WIDTH/CNT_WIDTH combination");
        end
    endgenerate

    seq_alu_state_t state;
    seq_alu_state_t next_state;

    logic [4:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         accept;
    logic [SHW-1:0] shamt;
    logic [W-1:0] base_result;
    logic [W-1:0] done_result;
    logic         done_illegal;

`ifdef SEQ_ALU_MULDIV_EN
    logic         core_start;
    logic         core_done;
    logic [W-1:0] core_result;
    logic [W-1:0] short_result;

    // Division by zero and signed overflow have fixed answers and skip the iteration.
    function automatic logic is_short(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic div_zero;
        logic ovf;
        div_zero = is_div(op) && (b == '0);
        ovf      = ((op == OP_DIV) || (op == OP_REM)) && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
        return div_zero || ovf;
    endfunction

    seq_alu_muldiv_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (core_start),
        .op_i    (func_op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .done_o  (core_done),
        .result_o(core_result)
    );
`endif

    assign accept  = valid_i && (state == IDLE);
    assign ready_o = (state == IDLE);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
`ifdef SEQ_ALU_MULDIV_EN
        core_start = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (valid_i) begin
`ifdef SEQ_ALU_MULDIV_EN
                    if (is_muldiv(func_op_i) && !is_short(func_op_i, a_i, b_i)) begin
                        core_start = 1'b1;
                        next_state = is_mul(func_op_i) ? MUL : DIV;
                    end else begin
                        next_state = DONE;
                    end
`else
                    next_state = DONE;
`endif
                end
            end
            MUL, DIV: begin
`ifdef SEQ_ALU_MULDIV_EN
                if (core_done) begin
                    next_state = DONE;
                end
`else
                next_state = IDLE;
`endif
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shamt       = b_q[SHW-1:0];
        base_result = '0;
        case (op_q)
            OP_ADD:  base_result = a_q + b_q;
            OP_SUB:  base_result = a_q - b_q;
            OP_AND:  base_result = a_q & b_q;
            OP_OR:   base_result = a_q | b_q;
            OP_XOR:  base_result = a_q ^ b_q;
            OP_SLTU: base_result = {{(W-1){1'b0}}, (a_q < b_q)};
            OP_SLT:  base_result = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL:  base_result = a_q << shamt;
            OP_SRL:  base_result = a_q >> shamt;
            OP_SRA:  base_result = W'($signed(a_q) >>> shamt);
            default: base_result = '0;
        endcase
    end

    // Pick the value registered in DONE from the base unit, a short-circuit or the core.
    always_comb begin
`ifdef SEQ_ALU_MULDIV_EN
        done_illegal = !is_base(op_q) && !is_muldiv(op_q);
        if (b_q == '0) begin
            short_result = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q;
        end else begin
            short_result = (op_q == OP_DIV) ? a_q : '0;
        end
`else
        done_illegal = !is_base(op_q);
`endif
        done_result = base_result;
`ifdef SEQ_ALU_MULDIV_EN
        if (is_muldiv(op_q)) begin
            done_result = is_short(op_q, a_q, b_q) ? short_result : core_result;
        end
`endif
        if (done_illegal) begin
            done_result = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            y_o       <= '0;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            if (accept) begin
                op_q <= func_op_i;
                a_q  <= a_i;
                b_q  <= b_i;
            end
            if (state == DONE) begin
                valid_o   <= 1'b1;
                illegal_o <= done_illegal;
                y_o       <= done_result;
            end
        end
    end

endmodule
